// File: rtl/fb_bank_ctrl_if.sv
// Frame-buffer bank controller signal bundle.
// master drives the event pulses; slave is the controller.
interface fb_bank_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             i_wr_start;
  logic             i_wr_done;
  logic             i_rd_vsync;
  logic             i_rd_done;
  logic             o_wr_bank;
  logic             o_wr_en;
  logic             o_rd_bank;
  logic             o_rd_req;
  logic [CNT_W-1:0] o_drop_cnt;
  logic [CNT_W-1:0] o_repeat_cnt;

  modport master (
    output i_wr_start, i_wr_done,
    output i_rd_vsync, i_rd_done,
    input  o_wr_bank, o_wr_en,
    input  o_rd_bank, o_rd_req,
    input  o_drop_cnt, o_repeat_cnt
  );

  modport slave (
    input  i_wr_start, i_wr_done,
    input  i_rd_vsync, i_rd_done,
    output o_wr_bank, o_wr_en,
    output o_rd_bank, o_rd_req,
    output o_drop_cnt, o_repeat_cnt
  );
endinterface

// File: rtl/fb_bank_ctrl.sv
// Ping-pong frame-buffer bank controller.
// Banks swap only at display vsync when a fresh frame exists.
module fb_bank_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  fb_bank_ctrl_if.slave bus
);
  typedef enum logic { W_IDLE, W_ACTIVE } w_st_t;
  typedef enum logic { R_IDLE, R_ACTIVE } r_st_t;

  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  w_st_t            r_ws, w_ws_n;
  r_st_t            r_rs, w_rs_n;
  logic             r_wr_bank, w_wr_bank_n;
  logic             r_rd_bank, w_rd_bank_n;
  logic             r_wr_en;
  logic             r_rd_req, w_req_n;
  logic             r_fresh, w_fresh_n;
  logic             r_have, w_have_n;
  logic             w_swap;
  logic             w_drop_inc;
  logic             w_rep_inc;
  logic [CNT_W-1:0] r_drop;
  logic [CNT_W-1:0] r_rep;

  always_comb begin
    w_ws_n      = r_ws;
    w_rs_n      = r_rs;
    w_wr_bank_n = r_wr_bank;
    w_rd_bank_n = r_rd_bank;
    w_fresh_n   = r_fresh;
    w_have_n    = r_have;
    w_req_n     = 1'b0;
    w_swap      = 1'b0;
    w_drop_inc  = 1'b0;
    w_rep_inc   = 1'b0;

    // done is retired first so vsync in the same cycle starts the next frame
    if (r_rs == R_ACTIVE && bus.i_rd_done)
      w_rs_n = R_IDLE;

    if (bus.i_rd_vsync) begin
      if (w_rs_n == R_IDLE) begin
        if (r_fresh) begin
          w_swap      = 1'b1;
          w_rd_bank_n = ~r_rd_bank;
          w_fresh_n   = 1'b0;
          w_have_n    = 1'b1;
          w_req_n     = 1'b1;
          w_rs_n      = R_ACTIVE;
        end else begin
          w_rep_inc = 1'b1;
          if (r_have) begin
            w_req_n = 1'b1;
            w_rs_n  = R_ACTIVE;
          end
        end
      end else begin
        w_rep_inc = 1'b1;
      end
    end

    unique case (r_ws)
      W_IDLE: begin
        if (bus.i_wr_start) begin
          w_ws_n      = W_ACTIVE;
          w_wr_bank_n = ~w_rd_bank_n;
          if (r_fresh && !w_swap) begin
            w_fresh_n  = 1'b0;
            w_drop_inc = 1'b1;
          end
        end
      end
      W_ACTIVE: begin
        if (bus.i_wr_start) begin
          w_drop_inc = 1'b1;
        end else if (bus.i_wr_done) begin
          w_ws_n    = W_IDLE;
          w_fresh_n = 1'b1;
        end
      end
      default: w_ws_n = W_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ws      <= W_IDLE;
      r_rs      <= R_IDLE;
      r_wr_bank <= 1'b1;
      r_rd_bank <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_req  <= 1'b0;
      r_fresh   <= 1'b0;
      r_have    <= 1'b0;
      r_drop    <= '0;
      r_rep     <= '0;
    end else begin
      r_ws      <= w_ws_n;
      r_rs      <= w_rs_n;
      r_wr_bank <= w_wr_bank_n;
      r_rd_bank <= w_rd_bank_n;
      r_wr_en   <= (w_ws_n == W_ACTIVE);
      r_rd_req  <= w_req_n;
      r_fresh   <= w_fresh_n;
      r_have    <= w_have_n;
      if (w_drop_inc && r_drop != CMAX)
        r_drop <= r_drop + 1'b1;
      if (w_rep_inc && r_rep != CMAX)
        r_rep <= r_rep + 1'b1;
    end
  end

  assign bus.o_wr_bank    = r_wr_bank;
  assign bus.o_wr_en      = r_wr_en;
  assign bus.o_rd_bank    = r_rd_bank;
  assign bus.o_rd_req     = r_rd_req;
  assign bus.o_drop_cnt   = r_drop;
  assign bus.o_repeat_cnt = r_rep;
endmodule

// File: tb/tb_fb_bank_ctrl.sv
// Scoreboard bench for fb_bank_ctrl: directed scenarios then
// random event pulses against an event-level reference model.
module tb_fb_bank_ctrl;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct packed {
    logic          wb;
    logic          we;
    logic          rb;
    logic          rq;
    logic [CW-1:0] dc;
    logic [CW-1:0] rc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q[$];

  fb_bank_ctrl_if #(.CNT_W(CW)) bus();

  fb_bank_ctrl #(.CNT_W(CW)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // reference model state, one variable per observable concept
  bit m_writing, m_reading, m_fresh, m_have, m_req;
  bit m_wbank, m_rbank;
  int m_drop, m_rep;

  function automatic int sat(int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  function automatic void m_reset();
    m_writing = 0; m_reading = 0; m_fresh = 0; m_have = 0;
    m_req = 0; m_wbank = 1; m_rbank = 0; m_drop = 0; m_rep = 0;
  endfunction

  function automatic void m_step(bit ws, bit wd, bit vs, bit rd);
    m_req = 0;
    if (m_reading && rd) m_reading = 0;
    if (vs) begin
      if (m_reading) m_rep = sat(m_rep);
      else if (m_fresh) begin
        m_rbank = !m_rbank;
        m_fresh = 0;
        m_have = 1;
        m_req = 1;
        m_reading = 1;
      end else begin
        m_rep = sat(m_rep);
        if (m_have) begin m_req = 1; m_reading = 1; end
      end
    end
    if (ws) begin
      if (m_writing) m_drop = sat(m_drop);
      else begin
        m_writing = 1;
        m_wbank = !m_rbank;
        // an unshown frame still pending is lost to this new capture
        if (m_fresh) begin m_fresh = 0; m_drop = sat(m_drop); end
      end
    end else if (wd && m_writing) begin
      m_writing = 0;
      m_fresh = 1;
    end
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    e.wb = m_wbank; e.we = m_writing; e.rb = m_rbank; e.rq = m_req;
    e.dc = CW'(m_drop); e.rc = CW'(m_rep);
    return e;
  endfunction

  function automatic exp_t act();
    exp_t a;
    a.wb = bus.o_wr_bank; a.we = bus.o_wr_en;
    a.rb = bus.o_rd_bank; a.rq = bus.o_rd_req;
    a.dc = bus.o_drop_cnt; a.rc = bus.o_repeat_cnt;
    return a;
  endfunction

  task automatic drive(bit ws, bit wd, bit vs, bit rd);
    @(negedge clk); #1;
    rstn = 1'b1;
    bus.i_wr_start = ws; bus.i_wr_done = wd;
    bus.i_rd_vsync = vs; bus.i_rd_done = rd;
    m_step(ws, wd, vs, rd);
    q.push_back(m_out());
  endtask

  task automatic drive_rst();
    @(negedge clk); #1;
    rstn = 1'b0;
    bus.i_wr_start = 0; bus.i_wr_done = 0;
    bus.i_rd_vsync = 0; bus.i_rd_done = 0;
    m_reset();
    q.push_back(m_out());
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic chk(string name, int a, int e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic chk_next(string name, int sel, int e);
    int a;
    @(posedge clk); #1;
    case (sel)
      0: a = bus.o_wr_bank;
      1: a = bus.o_wr_en;
      2: a = bus.o_rd_bank;
      3: a = bus.o_rd_req;
      4: a = bus.o_drop_cnt;
      default: a = bus.o_repeat_cnt;
    endcase
    chk(name, a, e);
  endtask

  // monitor: pop one expectation per cycle the DUT presents an update
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = act();
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL sb t=%0t: got wb=%b we=%b rb=%b rq=%b dc=%0d rc=%0d expected wb=%b we=%b rb=%b rq=%b dc=%0d rc=%0d",
                 $time, a.wb, a.we, a.rb, a.rq, a.dc, a.rc,
                 e.wb, e.we, e.rb, e.rq, e.dc, e.rc);
      end
      if (rstn && bus.o_wr_en === 1'b1) begin
        n_tests++;
        if (bus.o_wr_bank === bus.o_rd_bank) begin
          n_fail++;
          $display("FAIL bank_overlap t=%0t: got wb=%b rb=%b required differ",
                   $time, bus.o_wr_bank, bus.o_rd_bank);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.i_wr_start = 0; bus.i_wr_done = 0;
    bus.i_rd_vsync = 0; bus.i_rd_done = 0;
    m_reset();
    repeat (3) drive_rst();
    idle(1);

    drive(0, 0, 1, 0);
    chk_next("first_vsync_rep", 5, 1);
    idle(1);
    drive(1, 0, 0, 0);
    chk_next("first_wr_bank", 0, 1);
    idle(2);
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    chk_next("first_swap", 2, 1);
    idle(1);
    drive(0, 0, 0, 1);

    drive(1, 0, 0, 0);
    chk_next("second_wr_bank", 0, 0);
    idle(1);
    drive(0, 1, 0, 0);
    drive(0, 0, 1, 0);
    chk_next("second_swap", 2, 0);
    drive(0, 0, 0, 1);

    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    chk_next("capture_fast_drop", 4, 1);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 1);

    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      drive(0, 0, 0, 1);
    end
    chk_next("display_fast_rep", 5, 3);

    drive(1, 0, 0, 0);
    drive(0, 1, 1, 0);
    drive(1, 0, 1, 1);
    chk_next("start_swap_wb", 0, 1);
    chk("start_swap_drop", bus.o_drop_cnt, 1);
    drive(0, 0, 1, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);

    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0);
    chk_next("drop_saturate", 4, 3);

    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_wr_en", bus.o_wr_en, 0);
    chk("async_rst_wr_bank", bus.o_wr_bank, 1);
    chk("async_rst_drop", bus.o_drop_cnt, 0);
    repeat (2) drive_rst();
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 999) == 0) drive_rst();
    end
    idle(2);

    repeat (2) @(negedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
